// File: rtl/divmod_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | divmod_arbiter: two-requester round-robin front end for a shared divider.   |
// | Optional: DIVMOD_ARBITER_DIV0_BYPASS_EN answers denom==0 locally.           |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module divmod_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [1:0]            req_valid,
    input  logic [1:0]            req_unsgn_or_sgn,
    input  logic [1:0][WIDTH-1:0] req_num_i,
    input  logic [1:0][WIDTH-1:0] req_denom_i,
    output logic [1:0]            req_ack,
    output logic [1:0]            resp_valid,
    output logic [WIDTH-1:0]      resp_quot,
    output logic [WIDTH-1:0]      resp_rem,
    output logic                  div_enable,
    output logic                  div_unsgn_or_sgn,
    output logic [WIDTH-1:0]      div_num,
    output logic [WIDTH-1:0]      div_denom,
    input  logic [WIDTH-1:0]      div_quot,
    input  logic [WIDTH-1:0]      div_rem,
    input  logic                  div_can_accept_cmd,
    input  logic                  div_data_ready
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    logic [1:0]       state_q, state_d;
    logic             last_grant_q, last_grant_d;
    logic             owner_q, owner_d;
    logic             armed_q, armed_d;
    logic             sgn_q, sgn_d;
    logic [1:0]       ack_q, ack_d;
    logic [WIDTH-1:0] num_q, num_d;
    logic [WIDTH-1:0] denom_q, denom_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             w_grant;

    // A tie goes to whoever was not served last; a lone requester always wins.
    always_comb begin
        w_grant = (req_valid == 2'b11) ? ~last_grant_q : req_valid[1];
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        armed_d      = armed_q;
        sgn_d        = sgn_q;
        ack_d        = 2'b00;
        num_d        = num_q;
        denom_d      = denom_q;
        quot_d       = quot_q;
        rem_d        = rem_q;
        case (state_q)
            S_IDLE: begin
                if ((|req_valid) && div_can_accept_cmd) begin
                    owner_d        = w_grant;
                    num_d          = req_num_i[w_grant];
                    denom_d        = req_denom_i[w_grant];
                    sgn_d          = req_unsgn_or_sgn[w_grant];
                    ack_d[w_grant] = 1'b1;
                    state_d        = S_ISSUE;
`ifdef DIVMOD_ARBITER_DIV0_BYPASS_EN
                    if (req_denom_i[w_grant] == '0) begin
                        quot_d  = '1;
                        rem_d   = req_num_i[w_grant];
                        state_d = S_RESP;
                    end
`endif
                end
            end
            S_ISSUE: begin
                armed_d = 1'b0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // The first WAIT cycle may still see the previous command's ready.
                if (!armed_q) begin
                    armed_d = 1'b1;
                end else if (div_data_ready) begin
                    quot_d  = div_quot;
                    rem_d   = div_rem;
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                last_grant_d = owner_q;
                state_d      = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            armed_q      <= 1'b0;
            sgn_q        <= 1'b0;
            ack_q        <= 2'b00;
            num_q        <= '0;
            denom_q      <= '0;
            quot_q       <= '0;
            rem_q        <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            armed_q      <= armed_d;
            sgn_q        <= sgn_d;
            ack_q        <= ack_d;
            num_q        <= num_d;
            denom_q      <= denom_d;
            quot_q       <= quot_d;
            rem_q        <= rem_d;
        end
    end

    assign req_ack          = ack_q;
    assign resp_valid[0]    = (state_q == S_RESP) && !owner_q;
    assign resp_valid[1]    = (state_q == S_RESP) &&  owner_q;
    assign resp_quot        = quot_q;
    assign resp_rem         = rem_q;
    assign div_enable       = (state_q == S_ISSUE);
    assign div_unsgn_or_sgn = sgn_q;
    assign div_num          = num_q;
    assign div_denom        = denom_q;

endmodule
`default_nettype wire

// File: tb/tb_divmod_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | tb_divmod_arbiter: scoreboard bench with a behavioural divider model.       |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_divmod_arbiter;
    localparam int W = 32;
`ifdef DIVMOD_ARBITER_DIV0_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef struct packed {
        logic [W-1:0] q;
        logic [W-1:0] r;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset_n = 1'b1;
    logic              rv0 = 1'b0, rv1 = 1'b0, sg0 = 1'b0, sg1 = 1'b0;
    logic [W-1:0]      n0 = '0, n1 = '0, d0 = '0, d1 = '0;
    logic [1:0]        req_valid, req_unsgn_or_sgn;
    logic [1:0][W-1:0] req_num_i, req_denom_i;
    logic [1:0]        req_ack, resp_valid;
    logic [W-1:0]      resp_quot, resp_rem, div_num, div_denom;
    logic              div_enable, div_unsgn_or_sgn, div_can_accept_cmd;
    logic [W-1:0]      div_quot = '0, div_rem = '0;
    logic              div_data_ready = 1'b0;

    assign req_valid        = {rv1, rv0};
    assign req_unsgn_or_sgn = {sg1, sg0};
    assign req_num_i        = {n1, n0};
    assign req_denom_i      = {d1, d0};

    divmod_arbiter #(.WIDTH(W)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_unsgn_or_sgn(req_unsgn_or_sgn),
        .req_num_i(req_num_i), .req_denom_i(req_denom_i),
        .req_ack(req_ack), .resp_valid(resp_valid),
        .resp_quot(resp_quot), .resp_rem(resp_rem),
        .div_enable(div_enable), .div_unsgn_or_sgn(div_unsgn_or_sgn),
        .div_num(div_num), .div_denom(div_denom),
        .div_quot(div_quot), .div_rem(div_rem),
        .div_can_accept_cmd(div_can_accept_cmd), .div_data_ready(div_data_ready)
    );

    int checks = 0, errors = 0;
    exp_t exp_q0[$], exp_q1[$];

    // Truncating division; x/0 gives all ones with the dividend as remainder.
    function automatic void ref_div(input logic [W-1:0] n, input logic [W-1:0] d,
                                    input logic s, output logic [W-1:0] q, output logic [W-1:0] r);
        longint sn, sd;
        if (d == '0) begin
            q = '1;
            r = n;
        end else if (s) begin
            sn = longint'($signed(n));
            sd = longint'($signed(d));
            q  = W'(sn / sd);
            r  = W'(sn % sd);
        end else begin
            q = n / d;
            r = n % d;
        end
    endfunction

    // Divider model: latency 0..4 cycles after the command, ready held until the next command.
    logic         dv_busy = 1'b0, dv_block = 1'b0;
    int           dv_lat_fixed = -1;
    assign div_can_accept_cmd = !dv_busy && !dv_block;

    initial begin
        logic [W-1:0] cn, cd, pq, pr;
        logic         cs, en_seen;
        int           cnt;
        cnt = 0;
        forever begin
            @(negedge clk);
            en_seen = (div_enable === 1'b1);
            cn = div_num; cd = div_denom; cs = div_unsgn_or_sgn;
            @(posedge clk);
            #1;
            if (en_seen) begin
                ref_div(cn, cd, cs, pq, pr);
                cnt = (dv_lat_fixed >= 0) ? dv_lat_fixed : int'($urandom_range(0, 4));
                if (cnt == 0) begin
                    div_quot = pq; div_rem = pr; div_data_ready = 1'b1; dv_busy = 1'b0;
                end else begin
                    div_data_ready = 1'b0; dv_busy = 1'b1;
                end
            end else if (dv_busy) begin
                cnt--;
                if (cnt == 0) begin
                    div_quot = pq; div_rem = pr; div_data_ready = 1'b1; dv_busy = 1'b0;
                end
            end
        end
    end

    // Monitor / scoreboard.
    logic [1:0]        pv = 2'b00;
    logic [1:0][W-1:0] pden;
    logic              pca = 1'b0;
    bit                m_last = 1'b1, m_owner = 1'b0, m_den0 = 1'b0, e;
    int                cyc = 0, ack_cnt = 0, resp_cnt = 0, en_cnt = 0, ack_cyc = 0, en_since = 0;
    logic [W-1:0]      hold_q = '0, hold_r = '0;
    int                grant_log[$];

    always @(negedge clk) begin
        logic [1:0] exp_ack, exp_rv;
        logic       exp_en;
        bit         have, tim_ok;
        exp_t       ex;
        cyc++;
        if (!reset_n) begin
            checks++;
            if (req_ack !== 2'b00 || resp_valid !== 2'b00 || div_enable !== 1'b0 ||
                resp_quot !== '0 || resp_rem !== '0 || div_num !== '0 ||
                div_denom !== '0 || div_unsgn_or_sgn !== 1'b0) begin
                errors++;
                $display("FAIL reset_outputs: ack=%b rv=%b en=%b q=%h r=%h num=%h den=%h sg=%b, required all zero",
                         req_ack, resp_valid, div_enable, resp_quot, resp_rem, div_num, div_denom, div_unsgn_or_sgn);
            end
            m_last = 1'b1; hold_q = '0; hold_r = '0;
            exp_q0.delete(); exp_q1.delete();
        end else begin
            exp_en = 1'b0;
            if (req_ack !== 2'b00) begin
                ack_cnt++; checks++;
                e       = (pv == 2'b11) ? ~m_last : pv[1];
                exp_ack = e ? 2'b10 : 2'b01;
                if (pv == 2'b00 || !pca || req_ack !== exp_ack) begin
                    errors++;
                    $display("FAIL grant: ack=%b required %b (valid=%b accept=%b last=%0d)",
                             req_ack, exp_ack, pv, pca, m_last);
                end
                m_owner = e; m_den0 = (pden[e] == '0);
                ack_cyc = cyc; en_since = 0;
                grant_log.push_back(int'(e));
                exp_en = !(BYP && m_den0);
            end
            if (div_enable === 1'b1 || exp_en) begin
                checks++;
                if (div_enable !== exp_en) begin
                    errors++;
                    $display("FAIL div_enable: got %b required %b", div_enable, exp_en);
                end
            end
            if (div_enable === 1'b1) begin
                en_cnt++; en_since++;
            end
            if (resp_valid !== 2'b00) begin
                resp_cnt++; checks++;
                exp_rv = m_owner ? 2'b10 : 2'b01;
                have   = m_owner ? (exp_q1.size() > 0) : (exp_q0.size() > 0);
                if (!have) begin
                    errors++;
                    $display("FAIL resp_unexpected: resp_valid=%b with nothing outstanding", resp_valid);
                end else begin
                    ex = m_owner ? exp_q1.pop_front() : exp_q0.pop_front();
                    if (resp_valid !== exp_rv || resp_quot !== ex.q || resp_rem !== ex.r) begin
                        errors++;
                        $display("FAIL resp_data: rv=%b q=%h r=%h required rv=%b q=%h r=%h",
                                 resp_valid, resp_quot, resp_rem, exp_rv, ex.q, ex.r);
                    end
                    hold_q = ex.q; hold_r = ex.r;
                    checks++;
                    if (BYP && m_den0) tim_ok = (cyc == ack_cyc) && (en_since == 0);
                    else               tim_ok = (cyc - ack_cyc >= 3) && (en_since == 1);
                    if (!tim_ok) begin
                        errors++;
                        $display("FAIL resp_timing: %0d cycles after ack with %0d enables", cyc - ack_cyc, en_since);
                    end
                end
                m_last = m_owner;
            end else begin
                checks++;
                if (resp_quot !== hold_q || resp_rem !== hold_r) begin
                    errors++;
                    $display("FAIL resp_hold: q=%h r=%h required q=%h r=%h", resp_quot, resp_rem, hold_q, hold_r);
                end
            end
        end
        pv = req_valid; pden = req_denom_i; pca = div_can_accept_cmd;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic start_req(input int i, input logic [W-1:0] n, input logic [W-1:0] d, input logic s);
        exp_t ex;
        ref_div(n, d, s, ex.q, ex.r);
        if (i == 0) begin n0 = n; d0 = d; sg0 = s; rv0 = 1'b1; exp_q0.push_back(ex); end
        else        begin n1 = n; d1 = d; sg1 = s; rv1 = 1'b1; exp_q1.push_back(ex); end
    endtask

    task automatic stop_req(input int i);
        if (i == 0) rv0 = 1'b0;
        else        rv1 = 1'b0;
    endtask

    task automatic wait_resp(input int i, input int budget);
        int k;
        bit got;
        k = 0; got = 1'b0;
        while (!got && k < budget) begin
            @(negedge clk);
            k++;
            if (resp_valid[i] === 1'b1) got = 1'b1;
        end
        if (!got) begin
            checks++; errors++;
            $display("FAIL resp_timeout: requester %0d got no resp_valid within %0d cycles", i, budget);
            stop_req(i);
            if (i == 0 && exp_q0.size() > 0) void'(exp_q0.pop_back());
            if (i == 1 && exp_q1.size() > 0) void'(exp_q1.pop_back());
        end
        tick(1);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        rv0 = 1'b0; rv1 = 1'b0;
        tick(2);
        reset_n = 1'b1;
        tick(1);
    endtask

    task automatic run_random(input int i, input int n_ops);
        logic [W-1:0] n, d;
        logic         s;
        int           gap;
        for (int k = 0; k < n_ops; k++) begin
            s = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 7))
                0: begin n = $urandom; d = '0; end
                1: begin n = 32'h8000_0000; d = '1; s = 1'b1; end
                2: begin n = $urandom_range(0, 1000); d = $urandom_range(1, 50); end
                default: begin
                    n = $urandom;
                    d = $urandom >> $urandom_range(0, 31);
                    if (d == '0) d = 32'd1;
                end
            endcase
            start_req(i, n, d, s);
            wait_resp(i, 200);
            gap = $urandom_range(0, 3);
            if (gap > 0) begin
                stop_req(i);
                tick(gap);
            end
        end
        stop_req(i);
    endtask

    initial begin
        int a0, e0, r0, sz, k;
        #2 reset_n = 1'b0;
        tick(3);
        reset_n = 1'b1;
        tick(1);

        // Single unsigned request: 100/7.
        start_req(0, 32'd100, 32'd7, 1'b0);
        @(negedge clk);
        checks++;
        if (req_ack !== 2'b00) begin
            errors++; $display("FAIL s1_early_ack: ack=%b required 00", req_ack);
        end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (req_ack !== 2'b01) begin
            errors++; $display("FAIL s1_ack: ack=%b required 01", req_ack);
        end
        wait_resp(0, 50);
        stop_req(0);
        tick(2);

        // Tie from reset: requester 0 first, then 1.
        do_reset();
        e0 = en_cnt; sz = grant_log.size();
        start_req(0, 32'd20, 32'd3, 1'b1);
        start_req(1, -32'sd20, 32'd3, 1'b1);
        wait_resp(0, 50);
        stop_req(0);
        wait_resp(1, 50);
        stop_req(1);
        checks++;
        if (en_cnt - e0 != 2 || grant_log.size() != sz + 2 || grant_log[sz] != 0 || grant_log[sz+1] != 1) begin
            errors++;
            $display("FAIL tie_order: enables=%0d grants=%0d first=%0d, required 2 enables, order 0 then 1",
                     en_cnt - e0, grant_log.size() - sz, (grant_log.size() > sz) ? grant_log[sz] : -1);
        end
        tick(2);

        // Both held for four operations: grants alternate.
        sz = grant_log.size();
        fork
            begin
                start_req(0, 32'd1000, 32'd9, 1'b0); wait_resp(0, 60);
                start_req(0, 32'd77, 32'd5, 1'b1);   wait_resp(0, 60);
                stop_req(0);
            end
            begin
                start_req(1, 32'd555, 32'd4, 1'b0);  wait_resp(1, 60);
                start_req(1, -32'sd99, 32'd10, 1'b1); wait_resp(1, 60);
                stop_req(1);
            end
        join
        checks++;
        if (grant_log.size() != sz + 4 || grant_log[sz] != 0 || grant_log[sz+1] != 1 ||
            grant_log[sz+2] != 0 || grant_log[sz+3] != 1) begin
            errors++;
            $display("FAIL alternate: %0d grants recorded, required 4 in order 0,1,0,1", grant_log.size() - sz);
        end
        tick(2);

        // Divider not accepting: no grant until it is.
        dv_block = 1'b1;
        a0 = ack_cnt;
        start_req(0, 32'd64, 32'd8, 1'b0);
        tick(6);
        checks++;
        if (ack_cnt != a0) begin
            errors++; $display("FAIL hold_off: %0d acks while divider busy, required 0", ack_cnt - a0);
        end
        dv_block = 1'b0;
        k = 0;
        while (ack_cnt == a0 && k < 10) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (ack_cnt != a0 + 1) begin
            errors++; $display("FAIL release_ack: %0d acks after release, required 1", ack_cnt - a0);
        end
        wait_resp(0, 50);
        stop_req(0);
        tick(2);

        // Reset during WAIT abandons the operation.
        dv_lat_fixed = 6;
        e0 = en_cnt;
        start_req(0, 32'd300, 32'd11, 1'b0);
        k = 0;
        while (en_cnt == e0 && k < 20) begin
            @(negedge clk);
            k++;
        end
        tick(1);
        r0 = resp_cnt;
        do_reset();
        tick(12);
        checks++;
        if (resp_cnt != r0) begin
            errors++; $display("FAIL reset_abandon: %0d responses after reset, required 0", resp_cnt - r0);
        end
        dv_lat_fixed = -1;
        start_req(1, 32'd12345, 32'd100, 1'b0);
        wait_resp(1, 50);
        stop_req(1);
        checks++;
        if (resp_cnt != r0 + 1) begin
            errors++; $display("FAIL after_reset: %0d responses, required 1", resp_cnt - r0);
        end
        tick(2);

        // Divide by zero.
        e0 = en_cnt;
        start_req(0, 32'd5, 32'd0, 1'b0);
        wait_resp(0, 50);
        stop_req(0);
        checks++;
        if (en_cnt - e0 != (BYP ? 0 : 1)) begin
            errors++;
            $display("FAIL div0_enable: %0d enables, required %0d", en_cnt - e0, BYP ? 0 : 1);
        end
        tick(2);

        // Randomised traffic from both requesters.
        fork
            run_random(0, 30);
            run_random(1, 30);
        join
        tick(5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
